// File: rtl/picorv32_mem_pkg.sv
// ============================================================================
// Module  : picorv32_mem_pkg
// Brief   : Shared types and constants for the picorv32 memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package picorv32_mem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

  // Counter preload: WAIT is left when the counter reads zero, so load N-1.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    return (wait_cycles > 0) ? CNT_W'(wait_cycles - 1) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_bram.sv
// ============================================================================
// Module  : mem_resp_bram
// Brief   : Single-port DEPTHx32 array, byte-enable write, registered read
//           returning pre-write data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_resp_bram
  import picorv32_mem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Sampled on the same edge as the write, so a store returns the old word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else if (en) begin
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/picorv32_mem_responder.sv
// ============================================================================
// Module  : picorv32_mem_responder
// Brief   : picorv32 native-interface memory target with programmable wait
//           states. Optional sticky error output under MEM_RESP_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int ADDR_LSB    = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [WORD_W-1:0] mem_rdata
`ifdef MEM_RESP_ERR_EN
  ,
  output logic              mem_err
`endif
);

  localparam int               c_aw        = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_wait_load = wait_load(WAIT_CYCLES);

  resp_state_t       r_state;
  resp_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_oor;

  logic              w_abort;
  logic              w_access;
  logic              w_in_range;
  logic [31:0]       w_acc_addr;
  logic [WORD_W-1:0] w_acc_wdata;
  logic [STRB_W-1:0] w_acc_wstrb;
  logic [WORD_W-1:0] w_bram_rdata;
  logic              w_unused;

  assign w_unused = mem_instr;
  assign w_abort  = (r_state == ST_WAIT) && !mem_valid;

  // The array is accessed on the edge that enters RESP: straight from the
  // bus when there are no wait states, from the captured request otherwise.
  assign w_access = ((r_state == ST_IDLE) && mem_valid && (WAIT_CYCLES == 0)) ||
                    ((r_state == ST_WAIT) && mem_valid && (r_cnt == '0));

  assign w_acc_addr  = (r_state == ST_IDLE) ? mem_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? mem_wdata : r_wdata;
  assign w_acc_wstrb = (r_state == ST_IDLE) ? mem_wstrb : r_wstrb;
  assign w_in_range  = (w_acc_addr >> ADDR_LSB) < 32'(DEPTH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = 1'b0;
    if (r_state == ST_RESP) begin
      mem_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if ((r_state == ST_IDLE) && mem_valid) begin
      r_cnt   <= c_wait_load;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wstrb;
    end else if ((r_state == ST_WAIT) && mem_valid && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Remembers that the last access missed the array so its data reads as 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_oor <= 1'b0;
    end else if (w_access) begin
      r_oor <= !w_in_range;
    end
  end

  mem_resp_bram #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_bram (
    .clk    (clk),
    .resetn (resetn),
    .en     (w_access && w_in_range),
    .wstrb  (w_acc_wstrb),
    .idx    (w_acc_addr[ADDR_LSB +: c_aw]),
    .wdata  (w_acc_wdata),
    .rdata  (w_bram_rdata)
  );

  assign mem_rdata = r_oor ? '0 : w_bram_rdata;

`ifdef MEM_RESP_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if ((w_access && !w_in_range) || w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;
`endif

endmodule

`default_nettype wire
